// File: rtl/shift_pkg.sv
// Shared types and constants for the shift sequencer: datapath mode encoding,
// controller state encoding and the transfer-length limit.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_RIGHT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam int MAX_LEN = 8;

  function automatic logic len_legal(input logic [3:0] len);
    return (len != 4'd0) && (len <= 4'(MAX_LEN));
  endfunction

endpackage

// File: rtl/shift_reg.sv
// 8-bit bidirectional shift register with parallel load; the asynchronous
// reset exists for reuse elsewhere and is expected to be tied off by callers.
module shift_reg
  import shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  mode_e      mode,
  input  logic       d,
  input  logic [7:0] par_i,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 8'h00;
    end else begin
      case (mode)
        MODE_LOAD:  q <= par_i;
        MODE_LEFT:  q <= {q[6:0], d};
        MODE_RIGHT: q <= {d, q[7:1]};
        default:    q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial shift sequencer: loads a parallel word, shifts it len times in the
// requested direction, then pulses done; illegal lengths pulse err instead.
module shift_seq_ctrl
  import shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       dir_i,
  input  logic [3:0] len_i,
  input  logic [7:0] data_i,
  input  logic       ser_i,
  output logic       ser_o,
  output logic [7:0] data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  state_e     state, state_nxt;
  mode_e      mode;
  logic [3:0] cnt;
  logic       dir_q;
  logic       err_q;
  logic       accept;
  logic       err_set;
  logic [7:0] par;
  logic [7:0] p;

  always_comb begin
    state_nxt = state;
    mode      = MODE_HOLD;
    par       = data_i;
    accept    = 1'b0;
    err_set   = 1'b0;
    if (rst) begin
      // Reset clears the datapath through a synchronous load of zero.
      mode = MODE_LOAD;
      par  = 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (len_legal(len_i)) begin
              mode      = MODE_LOAD;
              accept    = 1'b1;
              state_nxt = ST_SHIFT;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          mode = dir_q ? MODE_RIGHT : MODE_LEFT;
          if (cnt <= 4'd1) state_nxt = ST_DONE;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      dir_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_set;
      if (accept) begin
        cnt   <= len_i;
        dir_q <= dir_i;
      end else if (state == ST_SHIFT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  shift_reg u_shift_reg (
    .clk   (clk),
    .rst_n (1'b1),
    .mode  (mode),
    .d     (ser_i),
    .par_i (par),
    .q     (p)
  );

  assign data_o = p;
  assign ser_o  = dir_q ? p[0] : p[7];
  assign busy_o = (state == ST_SHIFT) || (state == ST_DONE);
  assign done_o = (state == ST_DONE);
  assign err_o  = err_q;

endmodule
